// File: rtl/fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_if
// Instruction bus between the fetch stage (master) and instruction memory
// (slave). Two independent handshakes: address phase, then data phase.
//   ir_addr        master->slave  read address
//   ir_addr_valid  master->slave  address phase valid
//   ir_addr_ready  slave->master  address accepted
//   ir_data        slave->master  returned instruction word
//   ir_data_valid  slave->master  data phase valid
//   ir_data_ready  master->slave  data accepted
// ----------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] ir_addr;
    logic                  ir_addr_valid;
    logic                  ir_addr_ready;
    logic [DATA_WIDTH-1:0] ir_data;
    logic                  ir_data_valid;
    logic                  ir_data_ready;

    modport master (
        output ir_addr,
        output ir_addr_valid,
        input  ir_addr_ready,
        input  ir_data,
        input  ir_data_valid,
        output ir_data_ready
    );

    modport slave (
        input  ir_addr,
        input  ir_addr_valid,
        output ir_addr_ready,
        output ir_data,
        output ir_data_valid,
        input  ir_data_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Converts a single-cycle fetch request into an
// address handshake followed by a data handshake on the instruction bus and
// returns the word with a one-cycle valid pulse. Also keeps a completed-fetch
// counter and a sticky overrun flag for debug. All outputs are registered.
//   clk             clock, rising edge
//   rst             asynchronous active-high reset
//   inst_fetch_i    fetch request pulse
//   pc_i            fetch address, sampled only when the request is accepted
//   bus             instruction bus, master side
//   inst_o          last fetched word, held until the next completion
//   inst_valid_o    one-cycle pulse when inst_o is updated
//   fetch_overrun_o sticky: request arrived while a fetch was in flight
//   fetch_count_o   completed fetches, wraps modulo 2^32
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_fetch_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    fetch_unit_if.master          bus,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic                  inst_valid_o,
    output logic                  fetch_overrun_o,
    output logic [31:0]           fetch_count_o
);

    localparam int unsigned CNT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e                state_q,      state_d;
    logic [ADDR_WIDTH-1:0] ir_addr_q,    ir_addr_d;
    logic                  addr_valid_q, addr_valid_d;
    logic                  data_ready_q, data_ready_d;
    logic [DATA_WIDTH-1:0] inst_q,       inst_d;
    logic                  inst_valid_q, inst_valid_d;
    logic                  overrun_q,    overrun_d;
    logic [CNT_WIDTH-1:0]  count_q,      count_d;

    // State and output registers; reset abandons any bus transaction at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ir_addr_q    <= '0;
            addr_valid_q <= 1'b0;
            data_ready_q <= 1'b0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            ir_addr_q    <= ir_addr_d;
            addr_valid_q <= addr_valid_d;
            data_ready_q <= data_ready_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            overrun_q    <= overrun_d;
            count_q      <= count_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        ir_addr_d    = ir_addr_q;
        addr_valid_d = addr_valid_q;
        data_ready_d = data_ready_q;
        inst_d       = inst_q;
        inst_valid_d = 1'b0;
        overrun_d    = overrun_q;
        count_d      = count_q;

        unique case (state_q)
            IDLE: begin
                if (inst_fetch_i) begin
                    ir_addr_d    = pc_i;
                    addr_valid_d = 1'b1;
                    state_d      = ADDR;
                end
            end
            ADDR: begin
                // Requests while busy are dropped but remembered for debug.
                if (inst_fetch_i) begin
                    overrun_d = 1'b1;
                end
                if (bus.ir_addr_ready) begin
                    addr_valid_d = 1'b0;
                    data_ready_d = 1'b1;
                    state_d      = DATA;
                end
            end
            DATA: begin
                // Also covers a request landing on the completing cycle.
                if (inst_fetch_i) begin
                    overrun_d = 1'b1;
                end
                if (bus.ir_data_valid) begin
                    inst_d       = bus.ir_data;
                    inst_valid_d = 1'b1;
                    data_ready_d = 1'b0;
                    count_d      = count_q + CNT_WIDTH'(1);
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                addr_valid_d = 1'b0;
                data_ready_d = 1'b0;
            end
        endcase
    end

    assign bus.ir_addr       = ir_addr_q;
    assign bus.ir_addr_valid = addr_valid_q;
    assign bus.ir_data_ready = data_ready_q;
    assign inst_o            = inst_q;
    assign inst_valid_o      = inst_valid_q;
    assign fetch_overrun_o   = overrun_q;
    assign fetch_count_o     = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
// Scoreboard bench: the driver pushes the expected completion (address,
// count, latency from the configured bus stalls) for each issued fetch; a
// monitor pops and compares on every inst_valid pulse. A bus responder plays
// instruction memory with programmable address/data stall cycles.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cnt;
        int          lat;
        int          issue_cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        inst_fetch;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fetch_overrun;
    logic [31:0] fetch_count;

    fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

    fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_fetch_i    (inst_fetch),
        .pc_i            (pc),
        .bus             (bus_if),
        .inst_o          (inst),
        .inst_valid_o    (inst_valid),
        .fetch_overrun_o (fetch_overrun),
        .fetch_count_o   (fetch_count)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        exp_q[$];
    logic [31:0] model_cnt = 0;
    logic        exp_ovr = 0;
    logic [31:0] cur_exp_addr = 0;
    int          n_issued = 0;
    int          ahs_count = 0;
    int          a_stall = 0;
    int          d_stall = 0;
    bit          early_mode = 0;
    int          a_wait = 0;
    int          d_wait = 0;
    logic [31:0] hs_addr = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory contents as seen by the bench.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h0050_0093;
        if (a == 32'h0000_0020) return 32'h0000_0013;
        return (a * 32'd2654435761) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Bus responder: stalls address/data phases by the configured counts.
    always @(negedge clk) begin
        if (rst) begin
            a_wait = 0;
            d_wait = 0;
            bus_if.ir_addr_ready = 1'b0;
            bus_if.ir_data_valid = 1'b0;
            bus_if.ir_data       = 32'h0;
        end else begin
            if (bus_if.ir_addr_valid) begin
                chk("ir_addr", bus_if.ir_addr, cur_exp_addr);
                if (a_wait < a_stall) begin
                    bus_if.ir_addr_ready = 1'b0;
                    a_wait++;
                end else begin
                    bus_if.ir_addr_ready = 1'b1;
                    a_wait = 0;
                    hs_addr = bus_if.ir_addr;
                    ahs_count++;
                end
            end else begin
                bus_if.ir_addr_ready = 1'($urandom_range(0, 1));
            end

            if (bus_if.ir_data_ready) begin
                if (d_wait < d_stall) begin
                    bus_if.ir_data_valid = 1'b0;
                    bus_if.ir_data       = $urandom;
                    d_wait++;
                end else begin
                    bus_if.ir_data_valid = 1'b1;
                    bus_if.ir_data       = mem_f(hs_addr);
                    d_wait = 0;
                end
            end else if (early_mode && bus_if.ir_addr_valid) begin
                bus_if.ir_data_valid = 1'b1;
                bus_if.ir_data       = 32'hDEAD_BEEF;
            end else begin
                // Stray data while not ready must be ignored.
                bus_if.ir_data_valid = 1'($urandom_range(0, 1));
                bus_if.ir_data       = $urandom;
            end
        end
    end

    // Monitor: every completion must match the oldest outstanding fetch.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && inst_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL inst_valid: unexpected pulse inst=%h (t=%0t)", inst, $time);
            end else begin
                e = exp_q.pop_front();
                chk("inst", inst, mem_f(e.pc));
                chk("fetch_count", fetch_count, e.cnt);
                chk("latency", 32'(cyc - e.issue_cyc + 1), 32'(e.lat));
                chk("fetch_overrun", {31'b0, fetch_overrun}, {31'b0, exp_ovr});
            end
        end
    end

    task automatic issue(input logic [31:0] a, input int as, input int ds, input bit early);
        a_stall    = as;
        d_stall    = ds;
        early_mode = early;
        inst_fetch = 1'b1;
        pc         = a;
        cur_exp_addr = a;
        model_cnt  = model_cnt + 32'd1;
        exp_q.push_back('{pc: a, cnt: model_cnt, lat: 3 + as + ds, issue_cyc: cyc + 1});
        n_issued++;
    endtask

    // Issue one fetch from a negedge in IDLE and wait for its completion.
    task automatic do_fetch(input logic [31:0] a, input int as, input int ds,
                            input bit ovr, input bit early, input int gap);
        int budget;
        issue(a, as, ds, early);
        @(negedge clk);
        inst_fetch = 1'b0;
        if (ovr) begin
            inst_fetch = 1'b1;
            pc         = 32'h0000_0040;
            exp_ovr    = 1'b1;
            @(negedge clk);
            inst_fetch = 1'b0;
            pc         = $urandom;
        end
        budget = 200;
        while (!inst_valid && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: no inst_valid for addr %h", a);
        end
        repeat (gap) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ir_addr"}, bus_if.ir_addr, 32'h0);
        chk({tag, "_addr_valid"}, {31'b0, bus_if.ir_addr_valid}, 32'h0);
        chk({tag, "_data_ready"}, {31'b0, bus_if.ir_data_ready}, 32'h0);
        chk({tag, "_inst"}, inst, 32'h0);
        chk({tag, "_inst_valid"}, {31'b0, inst_valid}, 32'h0);
        chk({tag, "_overrun"}, {31'b0, fetch_overrun}, 32'h0);
        chk({tag, "_count"}, fetch_count, 32'h0);
    endtask

    initial begin
        int budget;
        rst        = 1'b1;
        inst_fetch = 1'b0;
        pc         = 32'h0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait fetch.
        do_fetch(32'h0000_0010, 0, 0, 0, 0, 2);
        chk("zero_wait_count", fetch_count, 32'd1);
        // Stalled bus: 4 address stall cycles, 2 data stall cycles.
        do_fetch(32'h0000_0080, 4, 2, 0, 0, 1);
        // Early data during ADDR is ignored.
        do_fetch(32'h0000_0020, 2, 1, 0, 1, 1);
        chk("early_inst", inst, 32'h0000_0013);
        // Overrun in ADDR, then a back-to-back fetch.
        do_fetch(32'h0000_0100, 2, 1, 1, 0, 0);
        do_fetch(32'h0000_0104, 0, 0, 0, 0, 2);
        chk("overrun_sticky", {31'b0, fetch_overrun}, 32'h1);

        // Asynchronous reset while in DATA.
        issue(32'h0000_0030, 0, 8, 0);
        void'(exp_q.pop_back());
        @(negedge clk);
        inst_fetch = 1'b0;
        budget = 20;
        while (!bus_if.ir_data_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("reach_data", {31'b0, bus_if.ir_data_ready}, 32'h1);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        exp_q.delete();
        model_cnt = 32'h0;
        exp_ovr   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_fetch(32'h0000_0000, 0, 0, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            do_fetch($urandom & 32'hFFFF_FFFC, $urandom_range(0, 3), $urandom_range(0, 3),
                     ($urandom_range(0, 3) == 0), 0, $urandom_range(0, 2));
        end

        // Counter wrap with back-to-back completions.
        force dut.count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.count_q;
        @(negedge clk);
        chk("count_preload", fetch_count, 32'hFFFF_FFFF);
        model_cnt = 32'hFFFF_FFFF;
        do_fetch(32'h0000_0200, 0, 0, 0, 0, 0);
        do_fetch(32'h0000_0204, 0, 0, 0, 0, 2);
        chk("wrap_count", fetch_count, 32'd1);

        chk("addr_handshakes", 32'(ahs_count), 32'(n_issued));
        chk("pending_fetches", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
